// File: rtl/fwd_scoreboard_if.sv
// Decode-side bundle for the operand hazard scoreboard.
// Decode drives the instruction fields; the scoreboard returns selects and stall.
interface fwd_scoreboard_if #(
    parameter int NSTAGE = 2
);
    localparam int SELW = $clog2(NSTAGE + 1);

    logic            d_valid;
    logic [4:0]      d_rs1_addr;
    logic [4:0]      d_rs2_addr;
    logic            d_use_rs1;
    logic            d_use_rs2;
    logic [4:0]      d_rd_addr;
    logic            d_reg_we;
    logic            d_load;
    logic            d_flush;
    logic            hold;
    logic [SELW-1:0] rs1_sel;
    logic [SELW-1:0] rs2_sel;
    logic            lduse;
    logic            issue;
    logic [31:0]     stall_count;

    modport master (
        output d_valid, d_rs1_addr, d_rs2_addr,
        output d_use_rs1, d_use_rs2, d_rd_addr,
        output d_reg_we, d_load, d_flush, hold,
        input  rs1_sel, rs2_sel, lduse, issue,
        input  stall_count
    );

    modport slave (
        input  d_valid, d_rs1_addr, d_rs2_addr,
        input  d_use_rs1, d_use_rs2, d_rd_addr,
        input  d_reg_we, d_load, d_flush, hold,
        output rs1_sel, rs2_sel, lduse, issue,
        output stall_count
    );
endinterface

// File: rtl/fwd_scoreboard.sv
// Shift-register scoreboard of in-flight writes for the decode stage.
// Picks bypass sources per operand and requests load-use stalls.
module fwd_scoreboard #(
    parameter int NSTAGE   = 2,
    parameter int LOAD_LAT = 1,
    parameter int SELW     = $clog2(NSTAGE + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    fwd_scoreboard_if.slave sb
);
    localparam int CNTW = (LOAD_LAT > 0) ? $clog2(LOAD_LAT + 1) : 1;

    logic [NSTAGE-1:0] vld_q, vld_d;
    logic [4:0]        rd_q  [NSTAGE];
    logic [4:0]        rd_d  [NSTAGE];
    logic [CNTW-1:0]   cnt_q [NSTAGE];
    logic [CNTW-1:0]   cnt_d [NSTAGE];
    logic [31:0]       stall_q, stall_d;

    logic [SELW-1:0]   sel1, sel2;
    logic              haz1, haz2;
    logic              live, lduse, issue;

    // Scan oldest to youngest so the youngest match overrides.
    always_comb begin
        sel1 = '0;
        haz1 = 1'b0;
        sel2 = '0;
        haz2 = 1'b0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            if (vld_q[i] && rd_q[i] == sb.d_rs1_addr && sb.d_use_rs1) begin
                haz1 = (cnt_q[i] != '0);
                sel1 = haz1 ? '0 : SELW'(i + 1);
            end
            if (vld_q[i] && rd_q[i] == sb.d_rs2_addr && sb.d_use_rs2) begin
                haz2 = (cnt_q[i] != '0);
                sel2 = haz2 ? '0 : SELW'(i + 1);
            end
        end
    end

    assign live  = sb.d_valid & ~sb.d_flush;
    assign lduse = live & (haz1 | haz2);
    assign issue = live & ~sb.hold & ~lduse;

    always_comb begin
        vld_d[0] = issue & sb.d_reg_we & (sb.d_rd_addr != 5'd0);
        rd_d[0]  = sb.d_rd_addr;
        cnt_d[0] = sb.d_load ? CNTW'(LOAD_LAT) : '0;
        for (int i = 1; i < NSTAGE; i++) begin
            vld_d[i] = vld_q[i-1];
            rd_d[i]  = rd_q[i-1];
            cnt_d[i] = (cnt_q[i-1] != '0) ? cnt_q[i-1] - 1'b1 : '0;
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (lduse && !sb.hold && stall_q != 32'hFFFF_FFFF) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q   <= '0;
            stall_q <= '0;
            for (int i = 0; i < NSTAGE; i++) begin
                rd_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            stall_q <= stall_d;
            if (!sb.hold) begin
                vld_q <= vld_d;
                for (int i = 0; i < NSTAGE; i++) begin
                    rd_q[i]  <= rd_d[i];
                    cnt_q[i] <= cnt_d[i];
                end
            end
        end
    end

    assign sb.rs1_sel     = sel1;
    assign sb.rs2_sel     = sel2;
    assign sb.lduse       = lduse;
    assign sb.issue       = issue;
    assign sb.stall_count = stall_q;
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: default (2,1) and deep (3,2) configs.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_fwd_scoreboard;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fwd_scoreboard_if #(.NSTAGE(2)) ifa ();
    fwd_scoreboard_if #(.NSTAGE(3)) ifb ();

    fwd_scoreboard #(.NSTAGE(2), .LOAD_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .sb(ifa)
    );
    fwd_scoreboard #(.NSTAGE(3), .LOAD_LAT(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .sb(ifb)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_a(input logic v, input logic [4:0] r1, r2,
                         input logic u1, u2, input logic [4:0] rd,
                         input logic we, ld, fl, hd);
        ifa.d_valid = v;   ifa.d_rs1_addr = r1; ifa.d_rs2_addr = r2;
        ifa.d_use_rs1 = u1; ifa.d_use_rs2 = u2; ifa.d_rd_addr = rd;
        ifa.d_reg_we = we; ifa.d_load = ld; ifa.d_flush = fl; ifa.hold = hd;
    endtask

    task automatic set_b(input logic v, input logic [4:0] r1, r2,
                         input logic u1, u2, input logic [4:0] rd,
                         input logic we, ld, fl, hd);
        ifb.d_valid = v;   ifb.d_rs1_addr = r1; ifb.d_rs2_addr = r2;
        ifb.d_use_rs1 = u1; ifb.d_use_rs2 = u2; ifb.d_rd_addr = rd;
        ifb.d_reg_we = we; ifb.d_load = ld; ifb.d_flush = fl; ifb.hold = hd;
    endtask

    task automatic cyc_a(input logic v, input logic [4:0] r1, r2,
                         input logic u1, u2, input logic [4:0] rd,
                         input logic we, ld, fl, hd);
        @(negedge clk);
        set_a(v, r1, r2, u1, u2, rd, we, ld, fl, hd);
        #1;
    endtask

    task automatic cyc_b(input logic v, input logic [4:0] r1, r2,
                         input logic u1, u2, input logic [4:0] rd,
                         input logic we, ld, fl, hd);
        @(negedge clk);
        set_b(v, r1, r2, u1, u2, rd, we, ld, fl, hd);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_a(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // reset state
        cyc_a(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_sel1", 32'(ifa.rs1_sel), 0);
        check("rst_sel2", 32'(ifa.rs2_sel), 0);
        check("rst_lduse", 32'(ifa.lduse), 0);
        check("rst_issue", 32'(ifa.issue), 1);
        check("rst_cnt", ifa.stall_count, 0);
        rst_n = 1'b1;

        // add x5 ; add x6,x5,x5 ; reader of x5 ; reader of x5
        cyc_a(1, 1, 2, 1, 1, 5, 1, 0, 0, 0);
        check("add5_issue", 32'(ifa.issue), 1);
        cyc_a(1, 5, 5, 1, 1, 6, 1, 0, 0, 0);
        check("byp1_sel1", 32'(ifa.rs1_sel), 1);
        check("byp1_sel2", 32'(ifa.rs2_sel), 1);
        check("byp1_lduse", 32'(ifa.lduse), 0);
        cyc_a(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
        check("byp2_sel1", 32'(ifa.rs1_sel), 2);
        cyc_a(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
        check("retired_sel1", 32'(ifa.rs1_sel), 0);

        // lw x7 ; addi x8,x7,1
        cyc_a(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);
        check("lw7_issue", 32'(ifa.issue), 1);
        cyc_a(1, 7, 0, 1, 0, 8, 1, 0, 0, 0);
        check("lu_lduse", 32'(ifa.lduse), 1);
        check("lu_issue", 32'(ifa.issue), 0);
        check("lu_sel1", 32'(ifa.rs1_sel), 0);
        cyc_a(1, 7, 0, 1, 0, 8, 1, 0, 0, 0);
        check("lu2_lduse", 32'(ifa.lduse), 0);
        check("lu2_sel1", 32'(ifa.rs1_sel), 2);
        check("lu2_issue", 32'(ifa.issue), 1);
        check("lu2_cnt", ifa.stall_count, 1);

        // x0 never tracked; youngest of two x9 writers wins
        cyc_a(1, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        cyc_a(1, 0, 0, 1, 1, 9, 1, 0, 0, 0);
        check("x0_sel1", 32'(ifa.rs1_sel), 0);
        check("x0_sel2", 32'(ifa.rs2_sel), 0);
        check("x0_lduse", 32'(ifa.lduse), 0);
        cyc_a(1, 0, 0, 1, 1, 9, 1, 0, 0, 0);
        cyc_a(1, 9, 9, 1, 1, 0, 0, 0, 0, 0);
        check("young_sel1", 32'(ifa.rs1_sel), 1);
        check("young_sel2", 32'(ifa.rs2_sel), 1);

        // flushed load-use reader is squashed and leaves a bubble
        cyc_a(1, 0, 0, 0, 0, 10, 1, 1, 0, 0);
        cyc_a(1, 10, 0, 1, 0, 11, 1, 0, 1, 0);
        check("flush_lduse", 32'(ifa.lduse), 0);
        check("flush_issue", 32'(ifa.issue), 0);
        check("flush_cnt", ifa.stall_count, 1);
        cyc_a(1, 10, 11, 1, 1, 0, 0, 0, 0, 0);
        check("flush_sel1", 32'(ifa.rs1_sel), 2);
        check("flush_bubble", 32'(ifa.rs2_sel), 0);
        check("flush_lduse2", 32'(ifa.lduse), 0);

        // unused rs2 matching a load does not stall
        cyc_a(1, 0, 0, 0, 0, 12, 1, 1, 0, 0);
        cyc_a(1, 1, 12, 1, 0, 0, 0, 0, 0, 0);
        check("nouse_lduse", 32'(ifa.lduse), 0);
        check("nouse_issue", 32'(ifa.issue), 1);
        check("nouse_sel2", 32'(ifa.rs2_sel), 0);
        set_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // deep config: lw x3 then reader, with a hold in the stall
        cyc_b(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
        check("b_lw_issue", 32'(ifb.issue), 1);
        cyc_b(1, 3, 0, 1, 0, 4, 1, 0, 0, 0);
        check("b_st1_lduse", 32'(ifb.lduse), 1);
        check("b_st1_issue", 32'(ifb.issue), 0);
        check("b_st1_cnt", ifb.stall_count, 0);
        cyc_b(1, 3, 0, 1, 0, 4, 1, 0, 0, 1);
        check("b_hold_lduse", 32'(ifb.lduse), 1);
        check("b_hold_issue", 32'(ifb.issue), 0);
        check("b_hold_cnt", ifb.stall_count, 1);
        cyc_b(1, 3, 0, 1, 0, 4, 1, 0, 0, 0);
        check("b_st2_lduse", 32'(ifb.lduse), 1);
        check("b_st2_cnt", ifb.stall_count, 1);
        cyc_b(1, 3, 0, 1, 0, 4, 1, 0, 0, 0);
        check("b_go_lduse", 32'(ifb.lduse), 0);
        check("b_go_sel1", 32'(ifb.rs1_sel), 3);
        check("b_go_issue", 32'(ifb.issue), 1);
        check("b_go_cnt", ifb.stall_count, 2);
        set_b(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // reset in the middle of a stall
        cyc_a(1, 0, 0, 0, 0, 13, 1, 1, 0, 0);
        cyc_a(1, 13, 0, 1, 0, 0, 0, 0, 0, 0);
        check("mid_lduse", 32'(ifa.lduse), 1);
        rst_n = 1'b0;
        cyc_a(1, 13, 0, 1, 0, 0, 0, 0, 0, 0);
        check("rst2_sel1", 32'(ifa.rs1_sel), 0);
        check("rst2_lduse", 32'(ifa.lduse), 0);
        check("rst2_cnt", ifa.stall_count, 0);
        rst_n = 1'b1;

        // counter saturation
        @(negedge clk);
        set_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        force dut_a.stall_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut_a.stall_q;
        #1;
        check("sat_preload", ifa.stall_count, 32'hFFFF_FFFE);
        cyc_a(1, 0, 0, 0, 0, 14, 1, 1, 0, 0);
        cyc_a(1, 14, 0, 1, 0, 0, 0, 0, 0, 0);
        check("sat_lduse", 32'(ifa.lduse), 1);
        cyc_a(1, 0, 0, 0, 0, 15, 1, 1, 0, 0);
        check("sat_max", ifa.stall_count, 32'hFFFF_FFFF);
        cyc_a(1, 0, 15, 0, 1, 0, 0, 0, 0, 0);
        check("sat_lduse2", 32'(ifa.lduse), 1);
        cyc_a(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("sat_hold", ifa.stall_count, 32'hFFFF_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
